// File: rtl/rf_pkg.sv
// Shared types and defaults for the parameterised register file and its clear sequencer.
package rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } rf_state_e;

  localparam int RF_DW_DEF = 32;
  localparam int RF_AW_DEF = 5;

endpackage

// File: rtl/rf_clr_seq.sv
// Clear-sweep sequencer: walks an AW-bit counter across every register once per clr_req.
module rf_clr_seq
  import rf_pkg::*;
#(
  parameter int AW = RF_AW_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_en
);

  rf_state_e     state_r;
  logic [AW-1:0] cnt_r;
  logic          busy_r;

  // Sweep FSM; the terminal count is all-ones so the sweep never wraps into a second pass.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {AW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= {AW{1'b0}};
          if (clr_req) begin
            state_r <= SWEEP;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SWEEP: begin
          if (cnt_r == {AW{1'b1}}) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {AW{1'b0}};
          end else begin
            state_r <= SWEEP;
            busy_r  <= 1'b1;
            cnt_r   <= cnt_r + AW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {AW{1'b0}};
        end
      endcase
    end
  end

  assign clr_busy = busy_r;
  assign clr_en   = busy_r;
  assign clr_addr = cnt_r;

endmodule

// File: rtl/regfile_param.sv
// Two-read, one-write register file with a sequential clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_param
  import rf_pkg::*;
#(
  parameter int DW      = RF_DW_DEF,
  parameter int AW      = RF_AW_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  input  logic [AW-1:0] ad,
  input  logic [DW-1:0] di,
  input  logic          we,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          wr_drop,
  output logic [DW-1:0] do1,
  output logic [DW-1:0] do2
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic          wr_drop_r;
  logic [AW-1:0] clr_addr;
  logic          clr_en;
  logic          r0_fixed;

  assign r0_fixed = (ZERO_R0 != 0);

  rf_clr_seq #(
    .AW(AW)
  ) u_clr_seq (
    .CLK      (CLK),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_addr (clr_addr),
    .clr_en   (clr_en)
  );

  // Storage: the sweep owns the write port while active, and any user write then is dropped.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_drop_r <= 1'b0;
    end else if (clr_en) begin
      mem_r[clr_addr] <= {DW{1'b0}};
      wr_drop_r       <= we;
    end else begin
      wr_drop_r <= 1'b0;
      if (we && !(r0_fixed && ad == {AW{1'b0}})) begin
        mem_r[ad] <= di;
      end else begin
        mem_r[ad] <= mem_r[ad];
      end
    end
  end

  assign wr_drop = wr_drop_r;

`ifdef RF_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = we && !clr_busy && !(r0_fixed && ad == {AW{1'b0}});
`endif

  // Read muxes; register 0 is forced to zero when hard-wired.
  always_comb begin
    do1 = {DW{1'b0}};
    do2 = {DW{1'b0}};
    if (r0_fixed && a1 == {AW{1'b0}}) begin
      do1 = {DW{1'b0}};
`ifdef RF_BYPASS_EN
    end else if (fwd_ok && ad == a1) begin
      do1 = di;
`endif
    end else begin
      do1 = mem_r[a1];
    end
    if (r0_fixed && a2 == {AW{1'b0}}) begin
      do2 = {DW{1'b0}};
`ifdef RF_BYPASS_EN
    end else if (fwd_ok && ad == a2) begin
      do2 = di;
`endif
    end else begin
      do2 = mem_r[a2];
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed, table-driven bench for regfile_param (default DW=32, AW=5, ZERO_R0=1).
module tb_regfile_param;

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, ad;
  logic [31:0] di;
  logic        we, clr_req;
  logic        clr_busy, wr_drop;
  logic [31:0] do1, do2;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [4:0]  ad;
    logic [31:0] di;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [5];

  regfile_param dut (
    .CLK      (CLK),
    .reset    (reset),
    .a1       (a1),
    .a2       (a2),
    .ad       (ad),
    .di       (di),
    .we       (we),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .wr_drop  (wr_drop),
    .do1      (do1),
    .do2      (do2)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int k, input logic [31:0] v);
    we = 1'b1; ad = 5'(k); di = v;
    tick();
    we = 1'b0;
  endtask

  task automatic preload();
    for (int k = 0; k < 32; k++) wr(k, 32'(k * 10));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, {31'd0, clr_busy}, 32'd0);
  endtask

  task automatic rd(input int x, input int y);
    a1 = 5'(x); a2 = 5'(y);
    #1;
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 5'd0,  32'd77,     5'd0,  5'd1,  32'd0,      32'd10};
    vecs[1] = '{1'b1, 5'd5,  32'h0000abcd, 5'd5, 5'd4, 32'h0000abcd, 32'd40};
    vecs[2] = '{1'b0, 5'd0,  32'd0,      5'd5,  5'd6,  32'h0000abcd, 32'd60};
    vecs[3] = '{1'b1, 5'd5,  32'd50,     5'd30, 5'd31, 32'd300,    32'd310};
    vecs[4] = '{1'b0, 5'd0,  32'd0,      5'd5,  5'd0,  32'd50,     32'd0};

    reset = 1'b1; we = 1'b0; clr_req = 1'b0;
    a1 = 5'd0; a2 = 5'd0; ad = 5'd0; di = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    rd(5, 31);
    chk("reset_busy", {31'd0, clr_busy}, 32'd0);
    chk("reset_drop", {31'd0, wr_drop}, 32'd0);
    chk("reset_do1", do1, 32'd0);
    chk("reset_do2", do2, 32'd0);

    preload();
    for (int i = 0; i < 5; i++) begin
      we = vecs[i].we; ad = vecs[i].ad; di = vecs[i].di;
      a1 = vecs[i].a1; a2 = vecs[i].a2;
      tick();
      chk($sformatf("vec%0d_do1", i), do1, vecs[i].e1);
      chk($sformatf("vec%0d_do2", i), do2, vecs[i].e2);
      chk($sformatf("vec%0d_drop", i), {31'd0, wr_drop}, 32'd0);
    end
    we = 1'b0;

    for (int k = 0; k < 31; k++) begin
      rd(k, k + 1);
      chk($sformatf("pair%0d_do1", k), do1, (k == 0) ? 32'd0 : 32'(k * 10));
      chk($sformatf("pair%0d_do2", k), do2, 32'((k + 1) * 10));
    end

    // Same-cycle write/read of register 12.
    a1 = 5'd12; we = 1'b1; ad = 5'd12; di = 32'h55;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_same", do1, 32'h55);
`else
    chk("bypass_same", do1, 32'd120);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("bypass_next", do1, 32'h55);
    wr(12, 32'd120);

    // Full sweep with a stray clr_req in the middle.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      if (n == 10) begin
        rd(9, 20);
        chk("sweep10_r9", do1, 32'd0);
        chk("sweep10_r20", do2, 32'd200);
      end
      clr_req = (n == 15);
      tick();
      clr_req = 1'b0;
      n++;
    end
    chk("sweep_len", 32'(n), 32'd32);
    tick();
    chk("sweep_no_restart", {31'd0, clr_busy}, 32'd0);
    for (int k = 0; k < 32; k += 4) begin
      rd(k, 31 - k);
      chk($sformatf("swept%0d", k), do1 | do2, 32'd0);
    end

    // Write during sweep is dropped.
    preload();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    we = 1'b1; ad = 5'd30; di = 32'd7;
    tick();
    we = 1'b0;
    rd(30, 31);
    chk("drop_pulse", {31'd0, wr_drop}, 32'd1);
    chk("drop_r30_old", do1, 32'd300);
    tick();
    chk("drop_one_cycle", {31'd0, wr_drop}, 32'd0);
    wait_idle("drop_sweep_end");
    rd(30, 31);
    chk("drop_r30_after", do1, 32'd0);

    // Reset mid-sweep aborts it.
    preload();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1; we = 1'b1; ad = 5'd31; di = 32'd5;
    tick();
    reset = 1'b0; we = 1'b0;
    rd(31, 20);
    chk("abort_busy", {31'd0, clr_busy}, 32'd0);
    chk("abort_drop", {31'd0, wr_drop}, 32'd0);
    chk("abort_r31", do1, 32'd0);
    chk("abort_r20", do2, 32'd0);

    // Write and sweep request together: write lands, then gets swept.
    rd(3, 4);
    clr_req = 1'b1; we = 1'b1; ad = 5'd3; di = 32'd99;
    tick();
    clr_req = 1'b0; we = 1'b0;
    #1;
    chk("both_r3", do1, 32'd99);
    chk("both_busy", {31'd0, clr_busy}, 32'd1);
    wait_idle("both_sweep_end");
    #1;
    chk("both_r3_cleared", do1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter AW, default 5, meaning address width; depth = 2**AW registers.
REQ-003 The block SHALL have parameter ZERO_R0, default 1, meaning when 1 register 0 reads 0 and ignores writes.
REQ-004 The block SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have ports a1, a2  input  AW  read addresses, ports 1 and 2.
REQ-007 The block SHALL have ports ad  input  AW, di  input  DW, and we  input  1: write address, write data and write enable.
REQ-008 The block SHALL have port clr_req  input  1  request for a sequential clear sweep.
REQ-009 The block SHALL have port clr_busy  output  1  sweep in progress.
REQ-010 The block SHALL have port wr_drop  output  1  one-cycle pulse when a write is discarded.
REQ-011 The block SHALL have ports do1, do2  output  DW  read data, ports 1 and 2.

Function
REQ-012 Reads SHALL be combinational: do1 = reg[a1] and do2 = reg[a2], zero latency.
REQ-013 With ZERO_R0=1, a1=0 or a2=0 SHALL yield 0, and a write with ad=0 SHALL be accepted without effect and without wr_drop.
REQ-014 In IDLE, we=1 SHALL write di into reg[ad] at the rising edge; the new value SHALL be visible on reads from the following cycle.
REQ-015 The FSM SHALL have two states, IDLE and SWEEP; clr_req=1 in IDLE SHALL move it to SWEEP at the next edge with sweep counter = 0.
REQ-016 In SWEEP, each cycle SHALL zero reg[counter] and increment the counter; after clearing DEPTH-1, the FSM SHALL return to IDLE (sweep lasts DEPTH cycles).
REQ-017 clr_busy SHALL be 1 exactly while the state is SWEEP.
REQ-018 During SWEEP, clr_req SHALL be ignored.
REQ-019 During SWEEP, we=1 SHALL not write, and wr_drop SHALL be 1 in the cycle following that edge.
REQ-020 During SWEEP, reads SHALL return current contents: swept registers 0, unswept registers their old values.
REQ-021 The counter SHALL be AW bits wide, and the terminal count SHALL be detected at all-ones with no wrap into a second pass.
REQ-022 clr_req=1 and we=1 in the same IDLE cycle SHALL perform the write first, then start SWEEP; the sweep later clears that register.

Reset
REQ-023 reset=1 at a rising edge SHALL zero all registers, set state IDLE, counter 0, clr_busy 0 and wr_drop 0; reset has priority over we and clr_req.
REQ-024 reset asserted mid-SWEEP SHALL abort the sweep; after the edge all registers SHALL be 0 and the state IDLE.
REQ-025 Before the first reset edge, outputs SHALL be undefined; the bench SHALL not check them then.

Configuration
REQ-026 Macro RF_BYPASS_EN defined: if we=1 and IDLE and ad==a1 (resp. a2) and not (ZERO_R0 and ad==0), do1 (resp. do2) SHALL equal di combinationally in the same cycle.
REQ-027 Macro RF_BYPASS_EN undefined: reads SHALL show the old value until the cycle after the write; no bypass logic SHALL exist.

Structure
REQ-028 The shared package rf_pkg SHALL hold the FSM state typedef (IDLE, SWEEP) and the default DW/AW constants.
REQ-029 The sweep FSM and counter SHALL be sub-module rf_clr_seq (inputs CLK, reset, clr_req; outputs clr_busy, clr_addr, clr_en); storage and read muxes SHALL stay in regfile_param.

Verification
REQ-030 Reset, then write k*10 to reg k for k=0..31 at 10 ns each, then read pairs (k,k+1) -> reg[k]=10k for k≥1, and reg[0]=0 with ZERO_R0=1.
REQ-031 After REQ-030, pulse clr_req 1 cycle -> clr_busy=1 for exactly 32 cycles; at cycle 10 of the sweep reg[9]=0 and reg[20]=200; afterwards all reads 0.
REQ-032 In SWEEP cycle 5, we=1, ad=30, di=7 -> wr_drop=1 the next cycle and reg[30] not 7; after the sweep reg[30]=0.
REQ-033 With RF_BYPASS_EN, we=1, ad=a1=12, di=0x55 -> do1=0x55 in the same cycle; without the macro, do1 shows the old value, then 0x55 the next cycle.
REQ-034 Assert reset in sweep cycle 8 with regs preloaded 10k -> next cycle clr_busy=0 and reg[31]=0.
REQ-035 Simultaneous clr_req=1, we=1, ad=3, di=99 in IDLE -> reg[3]=99 one cycle later, then 0 once the sweep completes.
